// File: rtl/mem_io_ctrl.sv
// mem_io_ctrl: single-outstanding CPU load/store router between a memory
// port with fixed read latency and a small set of handshaked IO channels.
// Addresses 0xFFFFFC00-0xFFFFFFFF are IO; channel = cpu_addr[4 +: CW].
// Optional build macro MEM_IO_CTRL_IO_TIMEOUT_EN: IO waits for io_ready of
// the selected channel, bounded by TO_CYC cycles. Without it IO accesses
// complete after a single IO cycle and io_ready is not looked at.
module mem_io_ctrl #(
   parameter int DATA_W  = 32,
   parameter int IO_W    = 24,
   parameter int N_CH    = 4,
   parameter int MEM_LAT = 2,
   parameter int TO_CYC  = 255
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 cpu_rd,
   input  logic                 cpu_wr,
   input  logic [31:0]          cpu_addr,
   input  logic [DATA_W-1:0]    cpu_wdata,
   output logic [DATA_W-1:0]    cpu_rdata,
   output logic                 cpu_stall,
   output logic                 mem_en,
   output logic                 mem_we,
   output logic [31:0]          mem_addr,
   output logic [DATA_W-1:0]    mem_wdata,
   input  logic [DATA_W-1:0]    mem_rdata,
   output logic [N_CH-1:0]      io_sel,
   output logic                 io_rd,
   output logic                 io_wr,
   output logic [IO_W-1:0]      io_wdata,
   input  logic [N_CH*IO_W-1:0] io_rdata,
   input  logic [N_CH-1:0]      io_ready,
   output logic                 io_err
);

   localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
   // One extra bit so N_CH itself (e.g. 16 with CW=4) is representable.
   localparam logic [CW:0] NCH_L = (CW+1)'(N_CH);

   typedef enum logic [1:0] {IDLE, MEM, IO, DONE} state_t;

   state_t              state, state_nx;
   logic                write_q;     // captured direction (rd&wr counts as write)
   logic                first_q;     // first cycle after accept
   logic [2:0]          lat_cnt;     // memory read latency down-counter
   logic                req;
   logic                req_io;
   logic [CW-1:0]       req_ch;
   logic                req_ok;
   logic [CW-1:0]       ch;
   logic [N_CH-1:0]     sel_oh;
   logic [IO_W-1:0]     io_slice;
   logic                ch_ready;
   logic                rd_load;
   logic [DATA_W-1:0]   rd_val;
   logic                err_set;
`ifdef MEM_IO_CTRL_IO_TIMEOUT_EN
   logic [15:0]         to_cnt;      // IO cycles already spent waiting
`else
   logic                unused_ok;
   assign unused_ok = ^{io_ready, ch_ready};
`endif

   assign req      = cpu_rd | cpu_wr;
   assign req_io   = (cpu_addr[31:10] == 22'h3FFFFF);
   assign req_ch   = cpu_addr[4 +: CW];
   assign req_ok   = ({1'b0, req_ch} < NCH_L);
   // The active channel comes from the captured address.
   assign ch       = mem_addr[4 +: CW];
   assign io_wdata = mem_wdata[IO_W-1:0];

   // Channel demux: one-hot select plus the selected read slice and ready.
   always_comb begin
      sel_oh   = '0;
      io_slice = '0;
      ch_ready = 1'b0;
      for (int k = 0; k < N_CH; k++) begin
         if (ch == CW'(k)) begin
            sel_oh[k] = 1'b1;
            io_slice  = io_rdata[k*IO_W +: IO_W];
            ch_ready  = io_ready[k];
         end
      end
   end

   // Strobes and stall derive from state so reset clears them at once.
   always_comb begin
      cpu_stall = ((state == IDLE) && req) || (state == MEM) || (state == IO);
      mem_en    = (state == MEM) && first_q;
      mem_we    = (state == MEM) && first_q && write_q;
      io_sel    = (state == IO) ? sel_oh : '0;
      io_rd     = (state == IO) && !write_q;
      io_wr     = (state == IO) && write_q;
   end

   // Next state plus completion actions (read-data load, error set).
   always_comb begin
      state_nx = state;
      rd_load  = 1'b0;
      rd_val   = '0;
      err_set  = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               if (!req_io) begin
                  state_nx = MEM;
               end else if (req_ok) begin
                  state_nx = IO;
               end else begin
                  // Nonexistent channel: no strobe, straight to DONE.
                  state_nx = DONE;
                  err_set  = 1'b1;
                  rd_load  = !cpu_wr;
               end
            end
         end
         MEM: begin
            if (write_q) begin
               state_nx = DONE;
            end else if (lat_cnt == 3'd1) begin
               // Counter reaches 0 on this edge: data is valid now.
               state_nx = DONE;
               rd_load  = 1'b1;
               rd_val   = mem_rdata;
            end
         end
         IO: begin
`ifdef MEM_IO_CTRL_IO_TIMEOUT_EN
            // Ready is checked first so it wins over the timeout cycle.
            if (ch_ready) begin
               state_nx = DONE;
               rd_load  = !write_q;
               rd_val   = DATA_W'(io_slice);
            end else if (to_cnt == 16'(TO_CYC - 1)) begin
               state_nx = DONE;
               err_set  = 1'b1;
               rd_load  = !write_q;
            end
`else
            state_nx = DONE;
            rd_load  = !write_q;
            rd_val   = DATA_W'(io_slice);
`endif
         end
         default: state_nx = IDLE;   // DONE: held requests are ignored
      endcase
   end

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Request capture, counters, load result and sticky error.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mem_addr  <= '0;
         mem_wdata <= '0;
         write_q   <= 1'b0;
         first_q   <= 1'b0;
         lat_cnt   <= '0;
         cpu_rdata <= '0;
         io_err    <= 1'b0;
`ifdef MEM_IO_CTRL_IO_TIMEOUT_EN
         to_cnt    <= '0;
`endif
      end else begin
         if ((state == IDLE) && req) begin
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_wdata;
            write_q   <= cpu_wr;
            first_q   <= 1'b1;
            lat_cnt   <= 3'(MEM_LAT);
`ifdef MEM_IO_CTRL_IO_TIMEOUT_EN
            to_cnt    <= '0;
`endif
         end else begin
            first_q <= 1'b0;
            if ((state == MEM) && (lat_cnt != 3'd0))
               lat_cnt <= lat_cnt - 3'd1;
`ifdef MEM_IO_CTRL_IO_TIMEOUT_EN
            if (state == IO)
               to_cnt <= to_cnt + 16'd1;
`endif
         end
         if (rd_load) cpu_rdata <= rd_val;
         if (err_set) io_err    <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_io_ctrl.sv
// tb_mem_io_ctrl: directed scenarios plus random loads/stores, each checked
// against a transaction-level model of latency, strobes, result and error.
module tb_mem_io_ctrl;
   localparam int DATA_W  = 32;
   localparam int IO_W    = 24;
   localparam int N_CH    = 5;
   localparam int MEM_LAT = 2;
   localparam int TO_CYC  = 8;

   logic                 clock = 1'b0;
   logic                 reset = 1'b1;
   logic                 cpu_rd = 1'b0, cpu_wr = 1'b0;
   logic [31:0]          cpu_addr = '0;
   logic [DATA_W-1:0]    cpu_wdata = '0;
   logic [DATA_W-1:0]    cpu_rdata;
   logic                 cpu_stall;
   logic                 mem_en, mem_we;
   logic [31:0]          mem_addr;
   logic [DATA_W-1:0]    mem_wdata;
   logic [DATA_W-1:0]    mem_rdata = '0;
   logic [N_CH-1:0]      io_sel;
   logic                 io_rd, io_wr;
   logic [IO_W-1:0]      io_wdata;
   logic [N_CH*IO_W-1:0] io_rdata = '0;
   logic [N_CH-1:0]      io_ready = '0;
   logic                 io_err;

   int checks = 0;
   int failures = 0;
   logic [31:0] exp_rdata = '0;
   logic        exp_err = 1'b0;

   mem_io_ctrl #(.DATA_W(DATA_W), .IO_W(IO_W), .N_CH(N_CH), .MEM_LAT(MEM_LAT),
                 .TO_CYC(TO_CYC)) dut (
      .clock(clock), .reset(reset), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
      .cpu_stall(cpu_stall), .mem_en(mem_en), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .io_sel(io_sel), .io_rd(io_rd), .io_wr(io_wr), .io_wdata(io_wdata),
      .io_rdata(io_rdata), .io_ready(io_ready), .io_err(io_err));

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One CPU access. rdy_at = cycle (after accept) at which the selected
   // channel raises ready; dval = memory/IO read data offered.
   task automatic txn(input logic rd, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input int rdy_at, input logic [31:0] dval);
      bit is_io = (addr[31:10] == 22'h3FFFFF);
      int ch = int'(addr[6:4]);
      int exp_stall, exp_mem, exp_io;
      logic [31:0] new_rdata = exp_rdata;
      bit err_set = 0;
      int c = 0, n_stall = 0, n_mem = 0, n_we = 0, n_io = 0;
      bit done = 0;
      logic [N_CH-1:0] oh = '0;

      // Reference: latency and result straight from the access rules.
      if (!is_io) begin
         exp_mem = 1; exp_io = 0;
         exp_stall = wr ? 2 : MEM_LAT + 1;
         if (!wr) new_rdata = dval;
      end else if (ch >= N_CH) begin
         exp_mem = 0; exp_io = 0; exp_stall = 1; err_set = 1;
         if (!wr) new_rdata = 0;
      end else begin
         exp_mem = 0;
         oh[ch] = 1'b1;
`ifdef MEM_IO_CTRL_IO_TIMEOUT_EN
         if (rdy_at <= TO_CYC) begin
            exp_io = rdy_at;
            if (!wr) new_rdata = {8'h0, dval[IO_W-1:0]};
         end else begin
            exp_io = TO_CYC; err_set = 1;
            if (!wr) new_rdata = 0;
         end
`else
         exp_io = 1;
         if (!wr) new_rdata = {8'h0, dval[IO_W-1:0]};
`endif
         exp_stall = exp_io + 1;
      end

      @(negedge clock);
      cpu_rd = rd; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdata;
      while (!done && c < 40) begin
         mem_rdata = (c == MEM_LAT) ? dval : ~dval;
         for (int k = 0; k < N_CH; k++) begin
            io_rdata[k*IO_W +: IO_W] = (k == ch) ? dval[IO_W-1:0] : IO_W'($urandom);
            io_ready[k] = (k == ch) ? (c >= rdy_at) : 1'b1;
         end
         #1;
         if (cpu_stall) n_stall++; else done = 1;
         if (mem_en) begin
            n_mem++;
            if (mem_we) n_we++;
            chk("mem_addr", mem_addr, addr);
            if (wr) chk("mem_wdata", mem_wdata, wdata);
         end
         if (io_rd || io_wr) begin
            n_io++;
            chk("io_sel", io_sel, oh);
            chk("io_dir", io_wr, wr);
            if (wr) chk("io_wdata", io_wdata, wdata[IO_W-1:0]);
         end else begin
            chk("io_sel_idle", io_sel, 0);
         end
         if (!done) begin
            @(negedge clock);
            c++;
         end
      end
      if (!done) chk("done_bound", 0, 1);
      exp_rdata = new_rdata;
      exp_err   = exp_err | err_set;
      chk("stall_cycles", n_stall, exp_stall);
      chk("mem_en_cycles", n_mem, exp_mem);
      chk("mem_we_cycles", n_we, (exp_mem != 0 && wr) ? 1 : 0);
      chk("io_cycles", n_io, exp_io);
      chk("cpu_rdata", cpu_rdata, exp_rdata);
      chk("io_err", io_err, exp_err);
      @(negedge clock);
      cpu_rd = 1'b0; cpu_wr = 1'b0;
      #1;
      chk("idle_stall", cpu_stall, 0);
   endtask

   initial begin
      logic [31:0] a, d;
      bit r, w;
      int kind;

      #12;
      chk("rst_stall", cpu_stall, 0);
      chk("rst_rdata", cpu_rdata, 0);
      chk("rst_strobes", {mem_en, mem_we, io_rd, io_wr, io_sel}, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_err", io_err, 0);
      @(negedge clock);
      reset = 1'b0;

      txn(1, 0, 32'h0000_0010, 32'h0, 0, 32'h1234_5678);
      txn(0, 1, 32'h0000_0004, 32'hA5A5_A5A5, 0, 32'h0);
      txn(1, 0, 32'hFFFF_FC20, 32'h0, 4, 32'h00AB_CDEF);
      txn(1, 0, 32'hFFFF_FC30, 32'h0, 100, 32'h0055_5555);
      txn(1, 1, 32'hFFFF_FC00, 32'h00C0_FFEE, 2, 32'h0);
      txn(0, 1, 32'hFFFF_FC70, 32'h1, 0, 32'h0);
      txn(1, 0, 32'hFFFF_FC60, 32'h0, 0, 32'h0);

      // Reset in the middle of a memory read abandons it.
      @(negedge clock);
      cpu_rd = 1'b1; cpu_addr = 32'h40;
      @(negedge clock);
      #1;
      chk("mid_mem_en", mem_en, 1);
      reset = 1'b1; cpu_rd = 1'b0;
      #1;
      chk("mid_rst_stall", cpu_stall, 0);
      chk("mid_rst_strobes", {mem_en, mem_we, io_rd, io_wr, io_sel}, 0);
      chk("mid_rst_rdata", cpu_rdata, 0);
      chk("mid_rst_err", io_err, 0);
      chk("mid_rst_addr", mem_addr, 0);
      @(negedge clock);
      reset = 1'b0;
      exp_rdata = '0;
      exp_err   = 1'b0;
      txn(1, 0, 32'h0000_0100, 32'h0, 0, 32'hDEAD_BEEF);

      for (int i = 0; i < 60; i++) begin
         kind = $urandom_range(0, 3);
         w = 1'($urandom_range(0, 1));
         r = !w || ($urandom_range(0, 1) == 1);
         d = $urandom;
         if (kind < 2) a = $urandom & 32'h7FFF_FFFF;
         else if (kind == 2) a = {22'h3FFFFF, 3'($urandom_range(0, N_CH - 1)), 7'($urandom)} ;
         else a = {22'h3FFFFF, 10'($urandom)};
         if (kind == 0) begin r = 1; w = 0; end
         txn(r, w, a, $urandom, $urandom_range(1, 10), d);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
